// File: rtl/ssqrt_if.sv
// ssqrt_if: operand/result handshake bundle for the ssqrt square-root block.
// It also carries the number format, so the block itself has no parameters.
//
// Parameters
//   WIDTH     total bits of a and f (two's complement)
//   FRACBITS  fraction bits of a and f
//
// Signals
//   in_valid   master -> slave   operand valid
//   in_ready   slave  -> master  block can accept an operand
//   a          master -> slave   operand, signed fixed point
//   out_valid  slave  -> master  result valid
//   out_ready  master -> slave   downstream accepts the result
//   f          slave  -> master  root, signed fixed point (never negative)
//   neg        slave  -> master  operand was negative, qualified by out_valid
//
// Modports: master (operand source / result sink), slave (the ssqrt block).

interface ssqrt_if #(
  parameter int WIDTH    = 16,
  parameter int FRACBITS = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             neg;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, f, neg
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, f, neg
  );

endinterface

// File: rtl/ssqrt.sv
// ssqrt: signed fixed-point square root, the inverse of the squarer.
// The operand is shifted left by FRACBITS to form the radicand, so the
// integer square root of the radicand is already in the operand's fixed-point
// format. One root bit is produced per clock by the restoring
// digit-by-digit method, trading throughput for a very small datapath.
// Negative operands skip the iteration and return f=0 with neg=1.
//
// Ports
//   clk    in  clock, all state on the rising edge
//   reset  in  asynchronous, active-high reset; aborts any operation in flight
//   g      ssqrt_if.slave: in_valid/in_ready/a operand side,
//          out_valid/out_ready/f/neg result side
//
// Build option
//   SSQRT_ROUND_EN  when defined, the root is rounded to nearest (using the
//                   final remainder) and saturated to the largest positive
//                   value; when undefined the root is truncated.

module ssqrt (
  input  logic   clk,
  input  logic   reset,
  ssqrt_if.slave g
);

  localparam int W  = g.WIDTH;
  localparam int FB = g.FRACBITS;
  // Number of root bits; the radicand is padded to an even 2*N bits.
  localparam int N  = (W + FB + 1) / 2;
  localparam int RW = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   rad;
  logic [N+1:0]    rem;
  logic [N-1:0]    root;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    f_reg;
  logic            neg_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  logic [N+1:0]    rem_shift;
  logic [N+1:0]    trial;
  logic [N+1:0]    rem_next;
  logic [N-1:0]    root_next;
  logic            take;
  logic [W-1:0]    f_final;

  // One restoring iteration: bring down the next two radicand bits and try
  // to subtract 4*root+1. The remainder never exceeds 2*root, so its top two
  // bits are always zero before the shift and nothing is lost.
  always_comb begin
    rem_shift = {rem[N-1:0], rad[RW-1 -: 2]};
    trial     = {root, 2'b01};
    take      = (rem_shift >= trial);
    rem_next  = take ? (rem_shift - trial) : rem_shift;
    root_next = {root[N-2:0], take};
  end

`ifdef SSQRT_ROUND_EN
  localparam logic [W:0] MAXPOS = {2'b00, {(W-1){1'b1}}};

  logic [W:0] root_wide;
  logic [W:0] rounded;
  logic       round_up;

  // With remainder r = R - q*q, sqrt(R) is nearer q+1 exactly when r > q.
  // The radicand is an integer, so the halfway case cannot occur.
  always_comb begin
    root_wide = (W+1)'(root_next);
    round_up  = (rem_next > {2'b00, root_next});
    rounded   = root_wide + {{W{1'b0}}, round_up};
    f_final   = (rounded > MAXPOS) ? MAXPOS[W-1:0] : rounded[W-1:0];
  end
`else
  // Truncation: the root bits are the result.
  always_comb begin
    f_final = W'(root_next);
  end
`endif

  // Control and datapath registers. in_ready and out_valid are registered
  // alongside the state so the handshake outputs are glitch-free. The last
  // CALC iteration writes the result straight into f, so DONE is entered
  // with the output already valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rad           <= '0;
      rem           <= '0;
      root          <= '0;
      cnt           <= '0;
      f_reg         <= '0;
      neg_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g.in_valid) begin
            in_ready_reg <= 1'b0;
            if (g.a[W-1]) begin
              f_reg         <= '0;
              neg_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end else begin
              rad     <= RW'({g.a, {FB{1'b0}}});
              rem     <= '0;
              root    <= '0;
              cnt     <= CW'(N - 1);
              neg_reg <= 1'b0;
              state   <= CALC;
            end
          end
        end

        CALC: begin
          rad  <= {rad[RW-3:0], 2'b00};
          rem  <= rem_next;
          root <= root_next;
          if (cnt == '0) begin
            f_reg         <= f_final;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (g.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign g.in_ready  = in_ready_reg;
  assign g.out_valid = out_valid_reg;
  assign g.f         = f_reg;
  assign g.neg       = neg_reg;

endmodule

// File: tb/tb_ssqrt.sv
// tb_ssqrt: self-checking bench for ssqrt with WIDTH=16, FRACBITS=8.
// Expected results come from a plain-arithmetic integer square root of
// a*256 (rounded when SSQRT_ROUND_EN is defined), queued at acceptance and
// compared by a monitor on every cycle the result is valid. Directed cases
// pin latency, backpressure and mid-operation reset; a randomized phase
// follows with random downstream readiness.

module tb_ssqrt;

  logic clk;
  logic reset;

  ssqrt_if #(.WIDTH(16), .FRACBITS(8)) g ();

  ssqrt dut (
    .clk   (clk),
    .reset (reset),
    .g     (g)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_f[$];
  logic        exp_neg[$];

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison with counting and one-line report on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: floor(sqrt(a*256)) by plain search, optional round-to-nearest.
  function automatic void modelSqrt(input logic [15:0] a_val, output logic [15:0] f_exp, output logic neg_exp);
    longint r;
    longint q;
    if (a_val[15]) begin
      f_exp   = 16'h0000;
      neg_exp = 1'b1;
      return;
    end
    r = longint'(a_val) * 256;
    q = 0;
    while ((q + 1) * (q + 1) <= r) q++;
`ifdef SSQRT_ROUND_EN
    if ((r - q * q) > q) q++;
    if (q > 32767) q = 32767;
`endif
    f_exp   = q[15:0];
    neg_exp = 1'b0;
  endfunction

  // Monitor: whenever a result is offered it must match the oldest
  // outstanding expectation; it is retired when the handshake completes.
  always @(negedge clk) begin
    if (!reset && g.out_valid) begin
      if (exp_f.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: out_valid=1 with nothing outstanding, f=%h neg=%b", g.f, g.neg);
      end else begin
        checkOutput("model_f", 32'(g.f), 32'(exp_f[0]));
        checkOutput("model_neg", 32'(g.neg), 32'(exp_neg[0]));
        if (g.out_ready) begin
          void'(exp_f.pop_front());
          void'(exp_neg.pop_front());
        end
      end
    end
  end

  // Present one operand and hold it until the accepting edge. Called and
  // returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [15:0] a_val);
    logic [15:0] fe;
    logic        ne;
    int          guard;
    guard = 0;
    while (!g.in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!g.in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=%b expected 1 within 200 cycles", g.in_ready);
    end
    g.a        = a_val;
    g.in_valid = 1'b1;
    @(posedge clk);
    modelSqrt(a_val, fe, ne);
    exp_f.push_back(fe);
    exp_neg.push_back(ne);
    #1;
    g.in_valid = 1'b0;
    g.a        = 16'($urandom);
  endtask

  // Count cycles from acceptance (cycle 0) until out_valid is seen.
  task automatic waitValid(output int lat);
    lat = 1;
    while (!g.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Directed operation with literal expectations and out_ready held high.
  task automatic runDirected(input string name, input logic [15:0] a_val, input logic [15:0] f_lit,
                             input logic neg_lit, input int lat_lit);
    int lat;
    applyStimulus(a_val);
    waitValid(lat);
    checkOutput({name, "_latency"}, 32'(lat), 32'(lat_lit));
    checkOutput({name, "_f"}, 32'(g.f), 32'(f_lit));
    checkOutput({name, "_neg"}, 32'(g.neg), 32'(neg_lit));
    @(posedge clk);
    #1;
    checkOutput({name, "_in_ready_after"}, 32'(g.in_ready), 32'd1);
  endtask

  // Let the outstanding result drain with random downstream readiness.
  task automatic drainRandom();
    int guard;
    guard = 0;
    while (exp_f.size() != 0 && guard < 300) begin
      g.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_f.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding expected 0", exp_f.size());
    end
    g.out_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] fe;
    logic        ne;
    logic [15:0] f_hold;
    int          lat;
    logic [15:0] a_rnd;

    g.in_valid  = 1'b0;
    g.a         = 16'h0000;
    g.out_ready = 1'b1;
    reset       = 1'b1;

    // Pin the model itself with hand-computed roots.
    modelSqrt(16'h0400, fe, ne);
    checkOutput("pin_model_4p0", 32'(fe), 32'h0200);
    modelSqrt(16'h7FFF, fe, ne);
    checkOutput("pin_model_7fff", 32'(fe), 32'h0B50);
    modelSqrt(16'h0003, fe, ne);
`ifdef SSQRT_ROUND_EN
    checkOutput("pin_model_0003", 32'(fe), 32'h001C);
`else
    checkOutput("pin_model_0003", 32'(fe), 32'h001B);
`endif
    modelSqrt(16'hFF00, fe, ne);
    checkOutput("pin_model_neg", 32'(ne), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(g.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(g.out_valid), 32'd0);
    checkOutput("reset_f", 32'(g.f), 32'd0);
    checkOutput("reset_neg", 32'(g.neg), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed operands");
    runDirected("sqrt_4p0", 16'h0400, 16'h0200, 1'b0, 13);
    runDirected("sqrt_2p0", 16'h0200, 16'h016A, 1'b0, 13);
    runDirected("sqrt_7fff", 16'h7FFF, 16'h0B50, 1'b0, 13);
    runDirected("sqrt_zero", 16'h0000, 16'h0000, 1'b0, 13);
`ifdef SSQRT_ROUND_EN
    runDirected("sqrt_0003", 16'h0003, 16'h001C, 1'b0, 13);
`else
    runDirected("sqrt_0003", 16'h0003, 16'h001B, 1'b0, 13);
`endif
    runDirected("sqrt_neg1", 16'hFF00, 16'h0000, 1'b1, 1);
    runDirected("sqrt_1p0", 16'h0100, 16'h0100, 1'b0, 13);
    runDirected("sqrt_8000", 16'h8000, 16'h0000, 1'b1, 1);

    $display("[TB] backpressure");
    g.out_ready = 1'b0;
    applyStimulus(16'h0900);
    waitValid(lat);
    checkOutput("bp_latency", 32'(lat), 32'd13);
    checkOutput("bp_f", 32'(g.f), 32'h0300);
    f_hold = g.f;
    for (int i = 0; i < 20; i++) begin
      g.in_valid = 1'(i % 2);
      g.a        = 16'($urandom);
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 32'(g.out_valid), 32'd1);
      checkOutput("bp_f_stable", 32'(g.f), 32'(f_hold));
      checkOutput("bp_in_ready", 32'(g.in_ready), 32'd0);
    end
    g.in_valid  = 1'b0;
    g.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 32'(g.in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(g.out_valid), 32'd0);

    $display("[TB] reset during calculation");
    applyStimulus(16'h7FFF);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_f.delete();
    exp_neg.delete();
    #1;
    checkOutput("abort_out_valid", 32'(g.out_valid), 32'd0);
    checkOutput("abort_f", 32'(g.f), 32'd0);
    checkOutput("abort_in_ready", 32'(g.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    runDirected("after_abort_9p0", 16'h0900, 16'h0300, 1'b0, 13);

    $display("[TB] randomized operands");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        a_rnd = 16'($urandom);
      else
        a_rnd = 16'($urandom_range(0, 32767));
      applyStimulus(a_rnd);
      drainRandom();
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_idle_in_ready", 32'(g.in_ready), 32'd1);
    checkOutput("final_queue_empty", 32'(exp_f.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
